// File: rtl/fccc_lock_reset_seq_if.sv
// Signal bundle between the CCC lock/reset sequencer and its environment.
// FCCC_LOCK_LOSS_COUNT_EN adds the saturating lock-loss counter output.
interface fccc_lock_reset_seq_if;
  logic       LOCK;
  logic       NDM_RESET_REQ;
  logic       SYS_RESETN;
  logic       CPU_RESETN;
  logic       LOCK_SYNC;
  logic       LOCK_LOST;
`ifdef FCCC_LOCK_LOSS_COUNT_EN
  logic [7:0] LOCK_LOSS_CNT;
`endif

  // master drives LOCK/request and observes resets; slave is the sequencer
  modport master (
    output LOCK, NDM_RESET_REQ,
`ifdef FCCC_LOCK_LOSS_COUNT_EN
    input  LOCK_LOSS_CNT,
`endif
    input  SYS_RESETN, CPU_RESETN, LOCK_SYNC, LOCK_LOST
  );

  modport slave (
    input  LOCK, NDM_RESET_REQ,
`ifdef FCCC_LOCK_LOSS_COUNT_EN
    output LOCK_LOSS_CNT,
`endif
    output SYS_RESETN, CPU_RESETN, LOCK_SYNC, LOCK_LOST
  );
endinterface

// File: rtl/fccc_lock_reset_seq.sv
// Ordered fabric/CPU reset release behind the CCC LOCK, with relock and debug reset.
// FCCC_LOCK_LOSS_COUNT_EN enables a saturating 8-bit lock-loss counter.
module fccc_lock_reset_seq #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned CPU_DELAY_CYCLES   = 16,
  parameter int unsigned REQ_HOLD_CYCLES    = 8,
  parameter int unsigned CNT_W              = 16
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  fccc_lock_reset_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST    = CNT_W'(REQ_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    RST_HOLD   = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE_CNT = 3'd2,
    SYS_REL    = 3'd3,
    RUN        = 3'd4,
    REQ_RST    = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   sys_resetn_q, sys_resetn_d;
  logic                   cpu_resetn_q, cpu_resetn_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   rst_rel_c;
  logic                   lock_next_c;
  logic                   loss_evt_c;

  // Synchronizer chains: reset release and LOCK
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rst_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.LOCK};
    end
  end

  assign rst_rel_c   = rst_sync_q[SYNC_STAGES-1];
  // FSM acts on the value LOCK_SYNC takes on this edge, so state and LOCK_SYNC move together
  assign lock_next_c = lock_sync_q[SYNC_STAGES-2];

  // Next-state, counter and reset-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_evt_c = 1'b0;
    case (state_q)
      RST_HOLD: begin
        cnt_d = '0;
        if (rst_rel_c) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_next_c) state_d = STABLE_CNT;
      end
      STABLE_CNT: begin
        if (!lock_next_c) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = SYS_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      SYS_REL: begin
        if (!lock_next_c) begin
          state_d    = WAIT_LOCK;
          cnt_d      = '0;
          loss_evt_c = 1'b1;
        end else if (cnt_q == CPU_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_next_c) begin
          state_d    = WAIT_LOCK;
          cnt_d      = '0;
          loss_evt_c = 1'b1;
        end else if (bus.NDM_RESET_REQ) begin
          state_d = REQ_RST;
          cnt_d   = '0;
        end
      end
      REQ_RST: begin
        if (!lock_next_c) begin
          state_d    = WAIT_LOCK;
          cnt_d      = '0;
          loss_evt_c = 1'b1;
        end else if ((cnt_q == REQ_LAST) && !bus.NDM_RESET_REQ) begin
          state_d = SYS_REL;
          cnt_d   = '0;
        end else if (cnt_q != REQ_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RST_HOLD;
        cnt_d   = '0;
      end
    endcase
    sys_resetn_d = (state_d == SYS_REL) || (state_d == RUN);
    cpu_resetn_d = (state_d == RUN);
    lock_lost_d  = lock_lost_q | loss_evt_c;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= RST_HOLD;
      cnt_q        <= '0;
      sys_resetn_q <= 1'b0;
      cpu_resetn_q <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sys_resetn_q <= sys_resetn_d;
      cpu_resetn_q <= cpu_resetn_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign bus.SYS_RESETN = sys_resetn_q;
  assign bus.CPU_RESETN = cpu_resetn_q;
  assign bus.LOCK_SYNC  = lock_sync_q[SYNC_STAGES-1];
  assign bus.LOCK_LOST  = lock_lost_q;

`ifdef FCCC_LOCK_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Saturating count of lock losses out of SYS_REL/RUN/REQ_RST
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_evt_c && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) loss_cnt_q <= 8'd0;
    else         loss_cnt_q <= loss_cnt_d;
  end

  assign bus.LOCK_LOSS_CNT = loss_cnt_q;
`endif

endmodule

// File: tb/tb_fccc_lock_reset_seq.sv
// Directed, table-driven bench for fccc_lock_reset_seq (8/4/3 cycle configuration).
// With FCCC_LOCK_LOSS_COUNT_EN it also drives 300 lock losses into the counter.
module tb_fccc_lock_reset_seq;

  typedef struct {
    logic resetn;
    logic lock;
    logic ndm;
    logic sys;
    logic cpu;
    logic ls;
    logic ll;
  } vec_t;

  logic CLK = 1'b0;
  logic RESETN;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  fccc_lock_reset_seq_if bus();

  fccc_lock_reset_seq #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .CPU_DELAY_CYCLES  (4),
    .REQ_HOLD_CYCLES   (3),
    .CNT_W             (16)
  ) dut (
    .CLK   (CLK),
    .RESETN(RESETN),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic void seg(int n, logic r, logic l, logic nd,
                              logic s, logic c, logic ls, logic ll);
    vec_t v;
    v.resetn = r; v.lock = l; v.ndm = nd;
    v.sys = s; v.cpu = c; v.ls = ls; v.ll = ll;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%b exp=%b t=%0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_sys"},   -1, bus.SYS_RESETN, 1'b0);
    check({tag, "_cpu"},   -1, bus.CPU_RESETN, 1'b0);
    check({tag, "_lsync"}, -1, bus.LOCK_SYNC,  1'b0);
    check({tag, "_llost"}, -1, bus.LOCK_LOST,  1'b0);
  endtask

  // Each vector: drive on the falling edge, check 1ns after the next rising edge
  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      RESETN            = vecs[i].resetn;
      bus.LOCK          = vecs[i].lock;
      bus.NDM_RESET_REQ = vecs[i].ndm;
      @(posedge CLK);
      #1;
      check({tag, "_sys"},   i, bus.SYS_RESETN, vecs[i].sys);
      check({tag, "_cpu"},   i, bus.CPU_RESETN, vecs[i].cpu);
      check({tag, "_lsync"}, i, bus.LOCK_SYNC,  vecs[i].ls);
      check({tag, "_llost"}, i, bus.LOCK_LOST,  vecs[i].ll);
    end
  endtask

`ifdef FCCC_LOCK_LOSS_COUNT_EN
  task automatic check8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s iter=%0d got=%0h exp=%0h", name, idx, act, exp);
    end
  endtask
`endif

  initial begin
    RESETN            = 1'b0;
    bus.LOCK          = 1'b0;
    bus.NDM_RESET_REQ = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_all_low("por");
`ifdef FCCC_LOCK_LOSS_COUNT_EN
    check8("por_losscnt", -1, bus.LOCK_LOSS_CNT, 8'h00);
`endif

    // Power-up; NDM pulses in STABLE_CNT and SYS_REL must be ignored
    seg(5, 1,0,0, 0,0,0,0);
    seg(1, 1,1,0, 0,0,0,0);
    seg(2, 1,1,1, 0,0,1,0);
    seg(6, 1,1,0, 0,0,1,0);
    seg(1, 1,1,0, 1,0,1,0);
    seg(1, 1,1,1, 1,0,1,0);
    seg(2, 1,1,0, 1,0,1,0);
    seg(3, 1,1,0, 1,1,1,0);
    // Lock loss in RUN
    seg(1, 1,0,0, 1,1,1,0);
    seg(3, 1,0,0, 0,0,0,1);
    // Relock, glitch at count 5, full restart of the 8+4 sequence
    seg(1, 1,1,0, 0,0,0,1);
    seg(6, 1,1,0, 0,0,1,1);
    seg(1, 1,0,0, 0,0,1,1);
    seg(2, 1,0,0, 0,0,0,1);
    seg(1, 1,1,0, 0,0,0,1);
    seg(8, 1,1,0, 0,0,1,1);
    seg(4, 1,1,0, 1,0,1,1);
    seg(3, 1,1,0, 1,1,1,1);
    // One-cycle debug reset request
    seg(1, 1,1,1, 0,0,1,1);
    seg(2, 1,1,0, 0,0,1,1);
    seg(4, 1,1,0, 1,0,1,1);
    seg(3, 1,1,0, 1,1,1,1);
    // Debug reset request held for 10 cycles
    seg(10, 1,1,1, 0,0,1,1);
    seg(4,  1,1,0, 1,0,1,1);
    seg(3,  1,1,0, 1,1,1,1);
    // LOCK loss and NDM request seen together, then relock into SYS_REL
    seg(1, 1,0,0, 1,1,1,1);
    seg(1, 1,0,1, 0,0,0,1);
    seg(2, 1,0,0, 0,0,0,1);
    seg(1, 1,1,0, 0,0,0,1);
    seg(8, 1,1,0, 0,0,1,1);
    seg(2, 1,1,0, 1,0,1,1);
    run_table("seq");

    // Asynchronous reset mid-SYS_REL, observed before the next edge
    #2;
    RESETN = 1'b0;
    #1;
    check_all_low("async");
    repeat (2) @(negedge CLK);

    // Release with LOCK already high; LOCK_LOST must be clear again
    vecs.delete();
    seg(1,  1,1,0, 0,0,0,0);
    seg(10, 1,1,0, 0,0,1,0);
    seg(4,  1,1,0, 1,0,1,0);
    seg(2,  1,1,0, 1,1,1,0);
    run_table("rerel");

`ifdef FCCC_LOCK_LOSS_COUNT_EN
    check8("losscnt_zero", -1, bus.LOCK_LOSS_CNT, 8'h00);
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      bus.LOCK = 1'b0;
      repeat (3) @(negedge CLK);
      if (i < 3 || i == 253 || i == 254 || i == 255 || i == 299)
        check8("losscnt", i, bus.LOCK_LOSS_CNT, (i < 255) ? 8'(i + 1) : 8'hFF);
      bus.LOCK = 1'b1;
      repeat (12) @(negedge CLK);
    end
    check8("losscnt_final", 300, bus.LOCK_LOSS_CNT, 8'hFF);
    check("losscnt_llost", 300, bus.LOCK_LOST, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
